// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } alu_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    count;
    logic             running;

    // product already folds in the current iteration so the last step needs no extra cycle
    assign product = acc + (mplr[0] ? mcand : '0);
    assign done    = running & (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= a;
            mplr    <= b;
            count   <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            acc   <= product;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops plus optional iterative multiply.
//   state | meaning
//   IDLE  | ready for an operation
//   MUL   | multiplier iterating, busy high
//   DONE  | Result/ALUFlags valid, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    alu_state_t state, state_nxt;

    logic             accept;
    logic             mul_sel;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [SW-1:0]    shamt;
    logic [SW-1:0]    lsl_idx;
    logic [SW-1:0]    lsr_idx;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    assign in_ready  = (state == IDLE) & ~reset;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL);
    assign accept    = in_valid & in_ready;
    assign mul_sel   = (MUL_EN != 0) && (ALUControl == OP_MUL);
    assign mul_start = accept & mul_sel;

    assign shamt   = b[SW-1:0];
    // 0 - shamt wraps to WIDTH - shamt in SW bits
    assign lsl_idx = SW'(WIDTH) - shamt;
    assign lsr_idx = shamt - SW'(1);

    always_comb begin
        sub     = (ALUControl == OP_SUB);
        sum     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_LSL: begin
                alu_res = a << shamt;
                alu_c   = (shamt != '0) ? a[lsl_idx] : 1'b0;
            end
            OP_LSR: begin
                alu_res = a >> shamt;
                alu_c   = (shamt != '0) ? a[lsr_idx] : 1'b0;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
        mul_flags         = '0;
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_product == '0);
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = mul_sel ? MUL : DONE;
            MUL:  if (mul_done) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Result   <= '0;
            ALUFlags <= '0;
        end else if (accept && !mul_sel) begin
            Result   <= alu_res;
            ALUFlags <= alu_flags;
        end else if ((state == MUL) && mul_done) begin
            Result   <= mul_product;
            ALUFlags <= mul_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=32, MUL_EN=1.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [35:0] sb_q[$];
    string       nm_q[$];

    alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%0h expected none", Result);
            end else begin
                logic [35:0] e;
                string       n;
                e = sb_q.pop_front();
                n = nm_q.pop_front();
                chk({n, "_result"}, {4'h0, Result}, {4'h0, e[31:0]});
                chk({n, "_flags"}, {32'h0, ALUFlags}, {32'h0, e[35:32]});
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] er, input logic [3:0] ef,
                         input int lat, input int nbusy_exp);
        int n;
        int nb;
        ALUControl = op;
        a          = aa;
        b          = bb;
        in_valid   = 1'b1;
        n          = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: got in_ready=0 expected 1", nm);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back({ef, er});
        nm_q.push_back(nm);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!out_valid && n < 200);
        chk({nm, "_latency"}, 36'(n), 36'(lat));
        chk({nm, "_busy_cycles"}, 36'(nb), 36'(nbusy_exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        ALUControl = OP_ADD;
        repeat (3) @(posedge clk);
        #1 chk("in_ready_during_reset", {35'h0, in_ready}, 36'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {35'h0, in_ready}, 36'h1);
        chk("rst_out_valid", {35'h0, out_valid}, 36'h0);
        chk("rst_busy", {35'h0, busy}, 36'h0);
        chk("rst_result", {4'h0, Result}, 36'h0);
        chk("rst_flags", {32'h0, ALUFlags}, 36'h0);
        @(posedge clk);
        #1;

        do_op("add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 4'b1001, 1, 0);
        do_op("sub_zero",   OP_SUB, 32'd5,         32'd5,       32'h0,         4'b0110, 1, 0);
        do_op("sub_borrow", OP_SUB, 32'd3,         32'd5,       32'hFFFF_FFFE, 4'b1000, 1, 0);
        do_op("mul_3x7",    OP_MUL, 32'd3,         32'd7,       32'd21,        4'b0000, 33, 32);
        do_op("mul_wrap",   OP_MUL, 32'h1_0000,    32'h1_0000,  32'h0,         4'b0100, 33, 32);
        do_op("lsl_31",     OP_LSL, 32'h1,         32'd31,      32'h8000_0000, 4'b1000, 1, 0);
        do_op("lsr_1",      OP_LSR, 32'h3,         32'd1,       32'h1,         4'b0010, 1, 0);
        do_op("lsl_0",      OP_LSL, 32'hF,         32'hFFFF_FFE0, 32'hF,       4'b0000, 1, 0);
        do_op("and",        OP_AND, 32'hF0F0,      32'hFF00,    32'hF000,      4'b0000, 1, 0);
        do_op("or_zero",    OP_OR,  32'h0,         32'h0,       32'h0,         4'b0100, 1, 0);

        out_ready = 1'b0;
        do_op("xor_bp", OP_XOR, 32'hFF, 32'h0F, 32'hF0, 4'b0000, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ALUControl = OP_ADD;
            a          = 32'd1;
            b          = 32'd1;
            in_valid   = 1'b1;
            @(negedge clk);
            chk("bp_hold_result", {4'h0, Result}, 36'hF0);
            chk("bp_in_ready", {35'h0, in_ready}, 36'h0);
            chk("bp_out_valid", {35'h0, out_valid}, 36'h1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {35'h0, in_ready}, 36'h1);
        chk("bp_release_out_valid", {35'h0, out_valid}, 36'h0);
        @(posedge clk);
        #1;

        ALUControl = OP_MUL;
        a          = 32'd3;
        b          = 32'd7;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", {35'h0, in_ready}, 36'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {35'h0, busy}, 36'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort_in_ready_reset", {35'h0, in_ready}, 36'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {35'h0, out_valid}, 36'h0);
        chk("abort_busy", {35'h0, busy}, 36'h0);
        chk("abort_result", {4'h0, Result}, 36'h0);
        chk("abort_flags", {32'h0, ALUFlags}, 36'h0);
        chk("abort_in_ready", {35'h0, in_ready}, 36'h1);
        @(posedge clk);
        #1;
        do_op("add_after_abort", OP_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 36'(sb_q.size()), 36'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
